div_issue_ctrl: RTL
===================

Name: div_issue_ctrl

Overview:
- Front-end sequencer for the iterative 32-bit signed divide unit.
- Accepts divide requests from the execute stage over a valid/ready handshake and holds the operands stable for the whole operation.
- Issues a one-cycle ctrl_div start pulse, waits for the divider's ready, then captures quotient and exception.
- Returns the result, with a tag, over a valid/ready response handshake. Adds a timeout guard and back-to-back issue.

Parameters:
TAG_W, 4, width of request/response tag
MIN_LAT, 33, cycles after the ctrl_div pulse before div_ready is trusted (masks stale ready from the previous op)
TIMEOUT, 64, cycle count in WAIT after which the op aborts

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid&&req_ready
req_dividend  in  32  signed dividend
req_divisor  in  32  signed divisor
req_tag  in  TAG_W  opaque tag
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_quotient  out  32  signed quotient
resp_exception  out  1  divide-by-zero flag
resp_timeout  out  1  divider never signalled ready
resp_tag  out  TAG_W  tag of the answered request
div_dividend  out  32  operand to divider, held stable
div_divisor  out  32  operand to divider, held stable
ctrl_div  out  1  divider start/clear pulse
div_result  in  32  divider quotient
div_ready  in  1  divider done
div_exception  in  1  divider zero-divisor flag
busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs 0, including operand registers, tag, cycle counter and ctrl_div. Reset mid-operation abandons the op; the divider is left running and its outputs are ignored.
- States: IDLE, START, WAIT, RESP.
- req_ready = (state==IDLE) || (state==RESP && resp_ready). Combinational, no dependence on req_valid.
- IDLE: on req_valid, latch dividend, divisor and tag into div_dividend, div_divisor and the tag register; go to START.
- START: ctrl_div=1 for exactly this cycle; cnt<=0; go to WAIT. ctrl_div is 0 in every other state.
- WAIT: cnt increments each cycle (6-bit saturating).
  - cnt >= MIN_LAT-1 && div_ready: capture div_result and div_exception; resp_timeout=0; go to RESP.
  - Otherwise, cnt == TIMEOUT-1: quotient<=0, exception<=0, resp_timeout<=1; go to RESP.
  - Ready takes priority over timeout when both occur in the same cycle.
  - div_ready while cnt < MIN_LAT-1 is ignored.
- RESP: resp_valid=1. The quotient, exception, timeout and tag outputs are registered and stable while resp_valid && !resp_ready.
  - resp_ready && req_valid in the same cycle: the response retires and the new request is latched; go directly to START (no IDLE bubble).
  - resp_ready alone: go to IDLE; resp_valid drops the next cycle.
- Operands change only at request acceptance, never during START/WAIT.
- Latency: accept at edge N -> ctrl_div high in cycle N+1 -> earliest resp_valid in cycle N+1+MIN_LAT+1.
- Throughput: one op per MIN_LAT+2 cycles with back-to-back issue.
- Negative results are passed through unchanged (two's complement from the divider).

Optional Feature:
DIV_ZERO_BYPASS_EN
- Defined: at acceptance, if req_divisor==0 the FSM goes IDLE->RESP directly, skipping START/WAIT. No ctrl_div pulse is issued. resp_quotient=0, resp_exception=1, resp_timeout=0. resp_valid rises the cycle after acceptance.
- Undefined: zero divisors take the normal path; the exception comes from div_exception and the quotient is whatever div_result holds.

Test Plan:
- 100/7, tag 3, with a behavioural 33-cycle divider model -> one ctrl_div pulse; resp_quotient=14, resp_exception=0, resp_tag=3; resp_valid in cycle 35 after accept.
- -100/7 -> resp_quotient=0xFFFFFFF2 (-14).
- 5/0 -> with DIV_ZERO_BYPASS_EN: resp_valid 1 cycle after accept, quotient 0, exception 1, no ctrl_div. Without it: exception 1 after the full latency.
- resp_ready held low 10 cycles in RESP -> outputs stable, req_ready=0; then resp_ready=1 with req_valid=1 (20/4) -> next cycle ctrl_div=1, later quotient 5.
- Divider model never asserts ready -> resp_timeout=1, quotient 0 at cnt=63. A stale div_ready held high from cycle 0 must not complete the op before cnt=32.
- reset_n pulsed low mid-WAIT -> same-cycle async clear: resp_valid=0, ctrl_div=0, busy=0. The next request then completes correctly.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - request/response sequencer in front of the iterative 32-bit signed divider
// Optional feature macro: DIV_ZERO_BYPASS_EN (answer zero-divisor requests without starting the divider)
module div_issue_ctrl #(
   parameter int TAG_W   = 4,
   parameter int MIN_LAT = 33,
   parameter int TIMEOUT = 64
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [31:0]      i_req_dividend,
   input  logic [31:0]      i_req_divisor,
   input  logic [TAG_W-1:0] i_req_tag,
   output logic             o_resp_valid,
   input  logic             i_resp_ready,
   output logic [31:0]      o_resp_quotient,
   output logic             o_resp_exception,
   output logic             o_resp_timeout,
   output logic [TAG_W-1:0] o_resp_tag,
   output logic [31:0]      o_div_dividend,
   output logic [31:0]      o_div_divisor,
   output logic             o_ctrl_div,
   input  logic [31:0]      i_div_result,
   input  logic             i_div_ready,
   input  logic             i_div_exception,
   output logic             o_busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [5:0] C_MIN_CNT = 6'(MIN_LAT - 1);
   localparam logic [5:0] C_TMO_CNT = 6'(TIMEOUT - 1);
   localparam logic [5:0] C_CNT_MAX = 6'h3f;

   logic [1:0]       r_state;
   logic [5:0]       r_cnt;
   logic [31:0]      r_dividend;
   logic [31:0]      r_divisor;
   logic [TAG_W-1:0] r_tag;
   logic [31:0]      r_quot;
   logic             r_exc;
   logic             r_tmo;

   logic [1:0]       w_state_nxt;
   logic             w_req_ready;
   logic             w_accept;
   logic             w_bypass;
   logic             w_ready_hit;
   logic             w_timeout_hit;

   // Held low during reset so every output reads 0 while reset_n is asserted.
   assign w_req_ready = i_reset_n &&
                        ((r_state == S_IDLE) || ((r_state == S_RESP) && i_resp_ready));
   assign w_accept    = i_req_valid && w_req_ready;

   // Ready before MIN_LAT-1 may be left over from the previous op, so it is masked.
   assign w_ready_hit   = (r_state == S_WAIT) && (r_cnt >= C_MIN_CNT) && i_div_ready;
   assign w_timeout_hit = (r_state == S_WAIT) && (r_cnt == C_TMO_CNT);

   always_comb begin
      w_bypass = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
      w_bypass = (i_req_divisor == 32'd0);
`else
      w_bypass = 1'b0;
`endif
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_req_valid) begin
               w_state_nxt = w_bypass ? S_RESP : S_START;
            end
         end
         S_START: begin
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (w_ready_hit || w_timeout_hit) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (i_resp_ready) begin
               if (i_req_valid) begin
                  w_state_nxt = w_bypass ? S_RESP : S_START;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= 6'd0;
         r_dividend <= 32'd0;
         r_divisor  <= 32'd0;
         r_tag      <= '0;
         r_quot     <= 32'd0;
         r_exc      <= 1'b0;
         r_tmo      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (w_accept) begin
            r_dividend <= i_req_dividend;
            r_divisor  <= i_req_divisor;
            r_tag      <= i_req_tag;
            if (w_bypass) begin
               r_quot <= 32'd0;
               r_exc  <= 1'b1;
               r_tmo  <= 1'b0;
            end
         end

         if (r_state == S_START) begin
            r_cnt <= 6'd0;
         end else if (r_state == S_WAIT) begin
            if (r_cnt != C_CNT_MAX) begin
               r_cnt <= r_cnt + 6'd1;
            end
            // A genuine ready wins over a timeout landing on the same cycle.
            if (w_ready_hit) begin
               r_quot <= i_div_result;
               r_exc  <= i_div_exception;
               r_tmo  <= 1'b0;
            end else if (w_timeout_hit) begin
               r_quot <= 32'd0;
               r_exc  <= 1'b0;
               r_tmo  <= 1'b1;
            end
         end
      end
   end

   assign o_req_ready      = w_req_ready;
   assign o_resp_valid     = (r_state == S_RESP);
   assign o_resp_quotient  = r_quot;
   assign o_resp_exception = r_exc;
   assign o_resp_timeout   = r_tmo;
   assign o_resp_tag       = r_tag;
   assign o_div_dividend   = r_dividend;
   assign o_div_divisor    = r_divisor;
   assign o_ctrl_div       = (r_state == S_START);
   assign o_busy           = (r_state != S_IDLE);

endmodule
